// File: rtl/change_dispenser_if.sv
// change_dispenser bus: change request and refills in,
// solenoid drives, status and tube inventory out.
interface change_dispenser_if #(
   parameter int CNT_W = 8
);
   logic [1:0]       change;
   logic             refill5;
   logic             refill10;
   logic             eject5;
   logic             eject10;
   logic             busy;
   logic             done;
   logic             short;
   logic [1:0]       short_amt;
   logic [CNT_W-1:0] cnt5;
   logic [CNT_W-1:0] cnt10;

   modport master (
      output change, refill5, refill10,
      input  eject5, eject10, busy, done, short,
      input  short_amt, cnt5, cnt10
   );

   modport slave (
      input  change, refill5, refill10,
      output eject5, eject10, busy, done, short,
      output short_amt, cnt5, cnt10
   );
endinterface

// File: rtl/change_dispenser.sv
// Pays out vending change by pulsing the Rs5/Rs10 coin-tube
// solenoids, tracking tube stock and reporting any shortfall.
module change_dispenser #(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2,
   parameter int CNT_W        = 8,
   parameter int INIT5        = 8,
   parameter int INIT10       = 8
) (
   input logic               clk,
   input logic               rst,
   change_dispenser_if.slave bus
);

   localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ?
                         PULSE_CYCLES : GAP_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PICK,
      S_PULSE,
      S_GAP,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       rem_q, rem_d;
   logic             sel10_q, sel10_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [CNT_W-1:0] cnt5_q, cnt5_d;
   logic [CNT_W-1:0] cnt10_q, cnt10_d;
   logic             ej5_q, ej5_d;
   logic             ej10_q, ej10_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             short_q, short_d;
   logic [1:0]       amt_q, amt_d;
   logic             dec5, dec10;

   // Sequencer: picks the largest stocked coin, times the
   // pulse and gap, and decides the registered outputs.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      sel10_d = sel10_q;
      tmr_d   = tmr_q;
      amt_d   = amt_q;
      ej5_d   = 1'b0;
      ej10_d  = 1'b0;
      done_d  = 1'b0;
      short_d = 1'b0;
      dec5    = 1'b0;
      dec10   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.change != 2'b00) begin
               rem_d   = bus.change;
               amt_d   = 2'b00;
               state_d = S_PICK;
            end
         end
         S_PICK: begin
            if (rem_q == 2'd0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (rem_q[1] && cnt10_q != '0) begin
               sel10_d = 1'b1;
               rem_d   = rem_q - 2'd2;
               dec10   = 1'b1;
               ej10_d  = 1'b1;
               tmr_d   = TW'(PULSE_CYCLES - 1);
               state_d = S_PULSE;
            end else if (cnt5_q != '0) begin
               sel10_d = 1'b0;
               rem_d   = rem_q - 2'd1;
               dec5    = 1'b1;
               ej5_d   = 1'b1;
               tmr_d   = TW'(PULSE_CYCLES - 1);
               state_d = S_PULSE;
            end else begin
               state_d = S_DONE;
               done_d  = 1'b1;
               short_d = 1'b1;
               amt_d   = rem_q;
            end
         end
         S_PULSE: begin
            if (tmr_q == '0) begin
               tmr_d   = TW'(GAP_CYCLES - 1);
               state_d = S_GAP;
            end else begin
               tmr_d  = tmr_q - TW'(1);
               ej10_d = sel10_q;
               ej5_d  = !sel10_q;
            end
         end
         S_GAP: begin
            if (tmr_q == '0) begin
               state_d = S_PICK;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Tube inventory: saturating refill, dispense decrement,
   // and a simultaneous refill+dispense cancels out.
   always_comb begin
      cnt5_d  = cnt5_q;
      cnt10_d = cnt10_q;
      unique case ({bus.refill5, dec5})
         2'b10: if (cnt5_q != '1) cnt5_d = cnt5_q + CNT_W'(1);
         2'b01: cnt5_d = cnt5_q - CNT_W'(1);
         default: cnt5_d = cnt5_q;
      endcase
      unique case ({bus.refill10, dec10})
         2'b10: if (cnt10_q != '1) cnt10_d = cnt10_q + CNT_W'(1);
         2'b01: cnt10_d = cnt10_q - CNT_W'(1);
         default: cnt10_d = cnt10_q;
      endcase
   end

   // State, inventory and output registers; reset aborts
   // any pulse and reloads the tube counts.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= 2'b00;
         sel10_q <= 1'b0;
         tmr_q   <= '0;
         cnt5_q  <= CNT_W'(INIT5);
         cnt10_q <= CNT_W'(INIT10);
         ej5_q   <= 1'b0;
         ej10_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         short_q <= 1'b0;
         amt_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         sel10_q <= sel10_d;
         tmr_q   <= tmr_d;
         cnt5_q  <= cnt5_d;
         cnt10_q <= cnt10_d;
         ej5_q   <= ej5_d;
         ej10_q  <= ej10_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         short_q <= short_d;
         amt_q   <= amt_d;
      end
   end

   assign bus.eject5    = ej5_q;
   assign bus.eject10   = ej10_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.short     = short_q;
   assign bus.short_amt = amt_q;
   assign bus.cnt5      = cnt5_q;
   assign bus.cnt10     = cnt10_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: requests push the
// expected payout, a monitor checks it at each done pulse.
module tb_change_dispenser;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   change_dispenser_if #(.CNT_W(8)) bus ();

   change_dispenser #(
      .PULSE_CYCLES(4),
      .GAP_CYCLES  (2),
      .CNT_W       (8),
      .INIT5       (8),
      .INIT10      (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int p5;
      int p10;
      int h5;
      int h10;
      int first;
      int lat;
      int sh;
      int amt;
      int c5;
      int c10;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   done_cyc[$];

   int m_busy, m_h5, m_h10, m_p5, m_p10, m_first, m_ov;
   bit prev5, prev10;

   task automatic check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d",
                  name, act, exp);
      end
   endtask

   function automatic void push_exp(int p5, int p10, int sh,
                                    int amt, int c5, int c10,
                                    int lat);
      exp_t x;
      x.p5    = p5;
      x.p10   = p10;
      x.h5    = p5 * 4;
      x.h10   = p10 * 4;
      x.first = (p5 + p10 > 0) ? 2 : 0;
      x.lat   = lat;
      x.sh    = sh;
      x.amt   = amt;
      x.c5    = c5;
      x.c10   = c10;
      sbq.push_back(x);
   endfunction

   function automatic void mon_clear();
      m_busy  = 0;
      m_h5    = 0;
      m_h10   = 0;
      m_p5    = 0;
      m_p10   = 0;
      m_first = 0;
      m_ov    = 0;
      prev5   = 1'b0;
      prev10  = 1'b0;
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: accumulates pulse activity while busy and
   // scores it against the oldest expectation at done.
   always @(negedge clk) begin
      if (rst) begin
         mon_clear();
      end else begin
         if (bus.busy) m_busy++;
         if (bus.eject5) begin
            m_h5++;
            if (!prev5) m_p5++;
         end
         if (bus.eject10) begin
            m_h10++;
            if (!prev10) m_p10++;
         end
         if ((bus.eject5 || bus.eject10) && m_first == 0)
            m_first = m_busy;
         if (bus.eject5 && bus.eject10) m_ov = 1;
         prev5  = bus.eject5;
         prev10 = bus.eject10;
         if (bus.done) begin
            done_cyc.push_back(cyc);
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done, expected none");
            end else begin
               e = sbq.pop_front();
               check("pulses5", m_p5, e.p5);
               check("pulses10", m_p10, e.p10);
               check("high5", m_h5, e.h5);
               check("high10", m_h10, e.h10);
               check("first_eject", m_first, e.first);
               check("latency", m_busy, e.lat);
               check("eject_overlap", m_ov, 0);
               check("short", int'(bus.short), e.sh);
               check("short_amt", int'(bus.short_amt), e.amt);
               check("cnt5", int'(bus.cnt5), e.c5);
               check("cnt10", int'(bus.cnt10), e.c10);
            end
            mon_clear();
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 100) begin
         tick();
         n++;
      end
      if (bus.busy) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: busy=1 after 100 cycles, expected 0");
      end
   endtask

   task automatic req(logic [1:0] code);
      bus.change = code;
      tick();
      bus.change = 2'b00;
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0;
      bus.change   = 2'b00;
      bus.refill5  = 1'b0;
      bus.refill10 = 1'b0;
      mon_clear();
      rst = 1'b1;
      repeat (2) tick();
      check("rst_eject5", int'(bus.eject5), 0);
      check("rst_eject10", int'(bus.eject10), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_short", int'(bus.short), 0);
      check("rst_short_amt", int'(bus.short_amt), 0);
      check("rst_cnt5", int'(bus.cnt5), 8);
      check("rst_cnt10", int'(bus.cnt10), 8);
      rst = 1'b0;

      push_exp(1, 0, 0, 0, 7, 8, 9);
      req(2'b01);
      push_exp(0, 1, 0, 0, 7, 7, 9);
      req(2'b10);
      push_exp(1, 1, 0, 0, 6, 6, 16);
      req(2'b11);

      push_exp(0, 1, 0, 0, 6, 5, 9);
      push_exp(0, 1, 0, 0, 6, 4, 9);
      d0 = done_cyc.size();
      bus.change = 2'b10;
      repeat (15) tick();
      bus.change = 2'b00;
      wait_idle();
      check("held_payouts", done_cyc.size() - d0, 2);
      if (done_cyc.size() >= d0 + 2)
         check("held_spacing",
               done_cyc[d0+1] - done_cyc[d0], 10);

      push_exp(0, 1, 0, 0, 6, 4, 9);
      bus.change = 2'b10;
      tick();
      bus.change   = 2'b00;
      bus.refill10 = 1'b1;
      tick();
      bus.refill10 = 1'b0;
      wait_idle();

      for (int i = 3; i >= 0; i--) begin
         push_exp(0, 1, 0, 0, 6, i, 9);
         req(2'b10);
      end

      push_exp(2, 0, 0, 0, 4, 0, 16);
      req(2'b10);
      push_exp(3, 0, 0, 0, 1, 0, 23);
      req(2'b11);
      push_exp(1, 0, 0, 0, 0, 0, 9);
      req(2'b01);
      push_exp(0, 0, 1, 1, 0, 0, 2);
      req(2'b01);
      push_exp(0, 0, 1, 3, 0, 0, 2);
      req(2'b11);
      repeat (3) tick();
      check("amt_hold", int'(bus.short_amt), 3);
      check("short_idle", int'(bus.short), 0);
      check("done_idle", int'(bus.done), 0);

      bus.refill10 = 1'b1;
      tick();
      bus.refill10 = 1'b0;
      check("refill10", int'(bus.cnt10), 1);
      push_exp(0, 1, 1, 1, 0, 0, 9);
      req(2'b11);

      bus.refill5 = 1'b1;
      repeat (260) tick();
      bus.refill5 = 1'b0;
      check("cnt5_sat", int'(bus.cnt5), 255);
      push_exp(1, 0, 0, 0, 254, 0, 9);
      req(2'b01);

      bus.change = 2'b01;
      tick();
      bus.change = 2'b00;
      tick();
      tick();
      check("mid_pulse_eject5", int'(bus.eject5), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_eject5", int'(bus.eject5), 0);
      check("abort_eject10", int'(bus.eject10), 0);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_done", int'(bus.done), 0);
      check("abort_cnt5", int'(bus.cnt5), 8);
      check("abort_cnt10", int'(bus.cnt10), 8);
      repeat (15) tick();
      check("abort_busy_later", int'(bus.busy), 0);

      push_exp(0, 1, 0, 0, 8, 7, 9);
      req(2'b10);

      check("queue_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
